// File: rtl/lbp_window_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module      : lbp_window_ctrl_if
// Description : Pixel-stream and window handshake bundle for the LBP window
//               controller. The controller sits on the slave modport; the
//               pixel source / LBP operator side uses the master modport.
// Revision    : 1.0 - initial release
// ============================================================================
interface lbp_window_ctrl_if #(
    parameter int ROW_W = 6,
    parameter int COL_W = 6
);
    // Upstream pixel stream
    logic             in_valid;
    logic             in_sof;
    logic             in_ready;
    // Delay-line shift enable
    logic             line_ce;
    // Downstream window handshake
    logic             win_valid;
    logic             win_ready;
    logic [ROW_W-1:0] win_row;
    logic [COL_W-1:0] win_col;
    // Frame status
    logic             busy;
    logic             frame_done;
    logic             frame_err;

    // Pixel source / window consumer side
    modport master (
        output in_valid,
        output in_sof,
        output win_ready,
        input  in_ready,
        input  line_ce,
        input  win_valid,
        input  win_row,
        input  win_col,
        input  busy,
        input  frame_done,
        input  frame_err
    );

    // Controller side
    modport slave (
        input  in_valid,
        input  in_sof,
        input  win_ready,
        output in_ready,
        output line_ce,
        output win_valid,
        output win_row,
        output win_col,
        output busy,
        output frame_done,
        output frame_err
    );
endinterface
`default_nettype wire

// File: rtl/lbp_window_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : lbp_window_ctrl
// Description : Sequencer for the 3x3 LBP neighbourhood delay line. Accepts a
//               raster pixel stream, drives the common shift enable of all
//               latch-based delay-line stages, tracks the raster position and
//               presents a window (centre row/col) once the line buffers hold
//               a complete, non-border neighbourhood. Upstream is stalled while
//               a presented window has not been consumed.
// Revision    : 1.0 - initial release
// ============================================================================
module lbp_window_ctrl #(
    parameter int IMG_W = 64,
    parameter int IMG_H = 48,
    parameter int COL_W = 6,
    parameter int ROW_W = 6
) (
    input  wire logic           clk,
    input  wire logic           rst,     // asynchronous, active-low
    lbp_window_ctrl_if.slave    bus
);

    // ------------------------------------------------------------------------
    // Constants
    // ------------------------------------------------------------------------
    localparam logic [1:0] c_st_idle = 2'd0;   // waiting for a frame
    localparam logic [1:0] c_st_fill = 2'd1;   // rows 0-1: line buffers filling
    localparam logic [1:0] c_st_run  = 2'd2;   // rows >= 2: windows produced

    localparam logic [COL_W-1:0] c_col_last = COL_W'(IMG_W - 1);
    localparam logic [ROW_W-1:0] c_row_last = ROW_W'(IMG_H - 1);
    localparam logic [ROW_W-1:0] c_row_one  = ROW_W'(1);
    localparam logic [ROW_W-1:0] c_row_two  = ROW_W'(2);
    localparam logic [COL_W-1:0] c_col_two  = COL_W'(2);

    // ------------------------------------------------------------------------
    // State and registers
    // ------------------------------------------------------------------------
    logic [1:0]       state_q,      state_d;
    logic [ROW_W-1:0] row_q,        row_d;
    logic [COL_W-1:0] col_q,        col_d;
    logic             win_valid_q,  win_valid_d;
    logic [ROW_W-1:0] win_row_q,    win_row_d;
    logic [COL_W-1:0] win_col_q,    win_col_d;
    logic             frame_done_q, frame_done_d;
    logic             frame_err_q,  frame_err_d;

    // ------------------------------------------------------------------------
    // Combinational helpers
    // ------------------------------------------------------------------------
    logic             w_stall;
    logic             w_accept;
    logic             w_sof_accept;
    logic [ROW_W-1:0] w_pix_row;
    logic [COL_W-1:0] w_pix_col;
    logic             w_col_wrap;
    logic             w_frame_end;
    logic             w_win_set;

    // Handshake: a presented, unconsumed window freezes the whole delay line.
    // Outside a frame only an SOF pixel is taken into the delay line.
    always_comb begin
        w_stall      = win_valid_q & ~bus.win_ready;
        w_accept     = bus.in_valid & ~w_stall &
                       ((state_q != c_st_idle) | bus.in_sof);
        w_sof_accept = w_accept & bus.in_sof;
    end

    // Raster position of the pixel being accepted; an SOF pixel is always
    // (0,0) regardless of where the counters were.
    always_comb begin
        w_pix_row   = w_sof_accept ? '0 : row_q;
        w_pix_col   = w_sof_accept ? '0 : col_q;
        w_col_wrap  = (w_pix_col == c_col_last);
        w_frame_end = w_accept & w_col_wrap & (w_pix_row == c_row_last);
        w_win_set   = w_accept & (w_pix_row >= c_row_two) &
                      (w_pix_col >= c_col_two);
    end

    // ------------------------------------------------------------------------
    // FSM: state register
    // ------------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= c_st_idle;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM: next-state logic, advanced only by accepted pixels
    always_comb begin
        state_d = state_q;
        if (w_accept) begin
            if (bus.in_sof) begin
                state_d = c_st_fill;
            end else begin
                case (state_q)
                    c_st_fill: begin
                        if ((w_pix_row == c_row_one) && w_col_wrap) begin
                            state_d = c_st_run;
                        end
                    end
                    c_st_run: begin
                        if (w_frame_end) begin
                            state_d = c_st_idle;
                        end
                    end
                    default: begin
                        state_d = state_q;
                    end
                endcase
            end
        end
    end

    // FSM: outputs; the shift enable is same-cycle so each latch stage
    // captures exactly the pixel presented with it
    always_comb begin
        bus.in_ready   = ~w_stall;
        bus.line_ce    = w_accept;
        bus.busy       = (state_q != c_st_idle);
        bus.win_valid  = win_valid_q;
        bus.win_row    = win_row_q;
        bus.win_col    = win_col_q;
        bus.frame_done = frame_done_q;
        bus.frame_err  = frame_err_q;
    end

    // ------------------------------------------------------------------------
    // Datapath
    // ------------------------------------------------------------------------

    // Counters point at the next expected pixel; they clear at frame end
    always_comb begin
        row_d = row_q;
        col_d = col_q;
        if (w_accept) begin
            if (w_col_wrap) begin
                col_d = '0;
                row_d = (w_pix_row == c_row_last) ? '0 : (w_pix_row + 1'b1);
            end else begin
                col_d = w_pix_col + 1'b1;
                row_d = w_pix_row;
            end
        end
    end

    // Window: set one cycle after the pixel completing it, held until taken.
    // Accept implies no stall, so a new set never overwrites an unconsumed one.
    always_comb begin
        win_valid_d = win_valid_q & ~bus.win_ready;
        win_row_d   = win_row_q;
        win_col_d   = win_col_q;
        if (w_win_set) begin
            win_valid_d = 1'b1;
            win_row_d   = w_pix_row - 1'b1;
            win_col_d   = w_pix_col - 1'b1;
        end
    end

    // Frame status pulses, registered so each lasts exactly one cycle
    always_comb begin
        frame_done_d = w_frame_end;
        frame_err_d  = w_sof_accept & (state_q != c_st_idle);
    end

    // Datapath registers
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            row_q        <= '0;
            col_q        <= '0;
            win_valid_q  <= 1'b0;
            win_row_q    <= '0;
            win_col_q    <= '0;
            frame_done_q <= 1'b0;
            frame_err_q  <= 1'b0;
        end else begin
            row_q        <= row_d;
            col_q        <= col_d;
            win_valid_q  <= win_valid_d;
            win_row_q    <= win_row_d;
            win_col_q    <= win_col_d;
            frame_done_q <= frame_done_d;
            frame_err_q  <= frame_err_d;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_lbp_window_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_lbp_window_ctrl
// Description : Directed self-checking bench for lbp_window_ctrl (4x3 image).
//               Expected windows are queued when a pixel is accepted and
//               compared when the window is presented / consumed.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_lbp_window_ctrl;

    localparam int IMG_W = 4;
    localparam int IMG_H = 3;
    localparam int COL_W = 2;
    localparam int ROW_W = 2;

    typedef struct {
        int r;
        int c;
    } win_t;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    lbp_window_ctrl_if #(.ROW_W(ROW_W), .COL_W(COL_W)) bus ();

    lbp_window_ctrl #(
        .IMG_W (IMG_W),
        .IMG_H (IMG_H),
        .COL_W (COL_W),
        .ROW_W (ROW_W)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    // Scoreboard and reference state
    win_t sb[$];
    int   m_row, m_col;
    bit   m_busy, m_wv, m_done, m_err;

    int n_tests = 0;
    int n_fail  = 0;
    int n_ce = 0, n_win = 0, n_done = 0, n_err = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One clock: drive at negedge, check, then advance the reference model
    task automatic cyc(input bit v, input bit s, input bit wr, output bit acc);
        bit   exp_ready;
        int   pr, pc;
        win_t w;
        @(negedge clk);
        bus.in_valid  = v;
        bus.in_sof    = s;
        bus.win_ready = wr;
        #1;
        exp_ready = !(m_wv && !wr);
        acc       = v && exp_ready && (m_busy || s);
        chk("in_ready",   {31'd0, bus.in_ready},   {31'd0, exp_ready});
        chk("line_ce",    {31'd0, bus.line_ce},    {31'd0, acc});
        chk("win_valid",  {31'd0, bus.win_valid},  {31'd0, m_wv});
        chk("busy",       {31'd0, bus.busy},       {31'd0, m_busy});
        chk("frame_done", {31'd0, bus.frame_done}, {31'd0, m_done});
        chk("frame_err",  {31'd0, bus.frame_err},  {31'd0, m_err});
        if (m_wv) begin
            w = sb[0];
            chk("win_row", {30'd0, bus.win_row}, w.r);
            chk("win_col", {30'd0, bus.win_col}, w.c);
            if (wr) begin
                void'(sb.pop_front());
                n_win++;
            end
        end
        if (bus.line_ce === 1'b1)    n_ce++;
        if (bus.frame_done === 1'b1) n_done++;
        if (bus.frame_err === 1'b1)  n_err++;

        m_done = 1'b0;
        m_err  = 1'b0;
        m_wv   = m_wv && !wr;
        if (acc) begin
            if (s) begin
                if (m_busy) m_err = 1'b1;
                pr     = 0;
                pc     = 0;
                m_busy = 1'b1;
            end else begin
                pr = m_row;
                pc = m_col;
            end
            if (pr >= 2 && pc >= 2) begin
                sb.push_back('{r: pr - 1, c: pc - 1});
                m_wv = 1'b1;
            end
            if (pc == IMG_W - 1) begin
                m_col = 0;
                if (pr == IMG_H - 1) begin
                    m_row  = 0;
                    m_busy = 1'b0;
                    m_done = 1'b1;
                end else begin
                    m_row = pr + 1;
                end
            end else begin
                m_col = pc + 1;
                m_row = pr;
            end
        end
    endtask

    // Present one pixel until accepted (bounded)
    task automatic send(input bit s, input bit wr);
        bit a;
        int k;
        k = 0;
        do begin
            cyc(1'b1, s, wr, a);
            k++;
        end while (!a && k < 20);
        chk("send_accept", {31'd0, a}, 32'd1);
    endtask

    task automatic idle(input int n, input bit wr);
        bit a;
        for (int i = 0; i < n; i++) cyc(1'b0, 1'b0, wr, a);
    endtask

    task automatic full_frame();
        send(1'b1, 1'b1);
        for (int i = 1; i < IMG_W * IMG_H; i++) send(1'b0, 1'b1);
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_win_valid"},  {31'd0, bus.win_valid},  32'd0);
        chk({tag, "_win_row"},    {30'd0, bus.win_row},    32'd0);
        chk({tag, "_win_col"},    {30'd0, bus.win_col},    32'd0);
        chk({tag, "_frame_done"}, {31'd0, bus.frame_done}, 32'd0);
        chk({tag, "_frame_err"},  {31'd0, bus.frame_err},  32'd0);
        chk({tag, "_busy"},       {31'd0, bus.busy},       32'd0);
        chk({tag, "_line_ce"},    {31'd0, bus.line_ce},    32'd0);
    endtask

    initial begin
        int ce0, win0, done0, err0;
        bit a;
        bus.in_valid  = 1'b0;
        bus.in_sof    = 1'b0;
        bus.win_ready = 1'b0;
        m_row = 0; m_col = 0;
        m_busy = 1'b0; m_wv = 1'b0; m_done = 1'b0; m_err = 1'b0;

        // Reset state
        repeat (3) @(negedge clk);
        #1;
        chk_reset_outputs("rst");
        @(negedge clk);
        rst = 1'b1;

        // Single frame, consumer always ready
        ce0 = n_ce; win0 = n_win; done0 = n_done; err0 = n_err;
        full_frame();
        idle(3, 1'b1);
        chk("t1_line_ce_cycles", n_ce - ce0, 12);
        chk("t1_windows",        n_win - win0, 2);
        chk("t1_frame_done",     n_done - done0, 1);
        chk("t1_frame_err",      n_err - err0, 0);

        // Non-SOF pixels while idle are discarded
        ce0 = n_ce;
        for (int i = 0; i < 4; i++) cyc(1'b1, 1'b0, 1'b1, a);
        idle(1, 1'b1);
        chk("t2_line_ce_cycles", n_ce - ce0, 0);

        // Stall on the first window, then release with no lost pixel
        win0 = n_win; done0 = n_done;
        send(1'b1, 1'b0);
        for (int i = 1; i < 11; i++) send(1'b0, 1'b0);
        idle(1, 1'b0);
        ce0 = n_ce;
        for (int i = 0; i < 3; i++) cyc(1'b1, 1'b0, 1'b0, a);
        chk("t3_stalled_ce", n_ce - ce0, 0);
        send(1'b0, 1'b1);
        idle(3, 1'b1);
        chk("t3_windows",    n_win - win0, 2);
        chk("t3_frame_done", n_done - done0, 1);

        // SOF reissued at pixel 7 restarts the frame
        win0 = n_win; done0 = n_done; err0 = n_err;
        send(1'b1, 1'b1);
        for (int i = 1; i < 6; i++) send(1'b0, 1'b1);
        send(1'b1, 1'b1);
        for (int i = 1; i < 12; i++) send(1'b0, 1'b1);
        idle(3, 1'b1);
        chk("t4_frame_err",  n_err - err0, 1);
        chk("t4_windows",    n_win - win0, 2);
        chk("t4_frame_done", n_done - done0, 1);

        // Asynchronous reset during pixel 10
        send(1'b1, 1'b1);
        for (int i = 1; i < 9; i++) send(1'b0, 1'b1);
        @(negedge clk);
        bus.in_valid  = 1'b1;
        bus.in_sof    = 1'b0;
        bus.win_ready = 1'b1;
        #2;
        rst = 1'b0;
        #1;
        chk_reset_outputs("t5_async");
        chk("t5_in_ready", {31'd0, bus.in_ready}, 32'd1);
        sb.delete();
        m_row = 0; m_col = 0;
        m_busy = 1'b0; m_wv = 1'b0; m_done = 1'b0; m_err = 1'b0;
        @(negedge clk);
        bus.in_valid = 1'b0;
        rst = 1'b1;
        win0 = n_win; done0 = n_done;
        full_frame();
        idle(3, 1'b1);
        chk("t5_windows",    n_win - win0, 2);
        chk("t5_frame_done", n_done - done0, 1);

        // Back-to-back frames
        win0 = n_win; done0 = n_done; err0 = n_err;
        full_frame();
        full_frame();
        idle(3, 1'b1);
        chk("t6_windows",    n_win - win0, 4);
        chk("t6_frame_done", n_done - done0, 2);
        chk("t6_frame_err",  n_err - err0, 0);
        chk("t6_sb_empty",   sb.size(), 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/lbp_window_ctrl.md
Name: lbp_window_ctrl

Overview:
- Sequences the pixel delay line that builds the 3x3 LBP neighbourhood window: two row-length line buffers plus window taps, all built from enable-gated parallel latches.
- Accepts a raster pixel stream and drives the common shift enable of every delay-line stage.
- Tracks row and column position and flags when the window holds a complete, non-border neighbourhood.
- Stalls upstream while the downstream LBP operator has not consumed the current window.

Parameters:
- IMG_W, 64, pixels per row; must be ≥3.
- IMG_H, 48, rows per frame; must be ≥3.
- COL_W, 6, column counter width; 2^COL_W ≥ IMG_W.
- ROW_W, 6, row counter width; 2^ROW_W ≥ IMG_H.

Ports:
- clk  in  1  single clock, rising edge.
- rst  in  1  asynchronous, active-low reset.
- in_valid  in  1  upstream pixel present.
- in_sof  in  1  marks first pixel of a frame; meaningful only with in_valid.
- in_ready  out  1  controller can accept a pixel this cycle.
- line_ce  out  1  shift enable to all delay-line stages; combinational.
- win_valid  out  1  delay line holds a complete window.
- win_ready  in  1  downstream consumes the window.
- win_row  out  ROW_W  row of the window centre.
- win_col  out  COL_W  column of the window centre.
- busy  out  1  frame in progress (state ≠ IDLE).
- frame_done  out  1  one-cycle pulse after the last pixel of a frame is accepted.
- frame_err  out  1  one-cycle pulse on in_sof while busy.

Behaviour:
- Reset (rst=0, asynchronous):
  - state=IDLE; row=0, col=0.
  - win_valid=0, win_row=0, win_col=0, frame_done=0, frame_err=0.
- Stall:
  - stall = win_valid & ~win_ready.
  - in_ready = ~stall, combinational.
- Accept:
  - accept = in_valid & in_ready & (state≠IDLE | in_sof).
  - line_ce = accept, combinational and same-cycle, so the latch captures the data presented with it.
- IDLE state:
  - in_ready follows the stall rule.
  - Pixels without in_sof are consumed and discarded; line_ce=0 for them.
- States:
  - IDLE: waiting for a frame.
  - FILL: rows 0–1.
  - RUN: rows ≥2.
- Transitions:
  - IDLE→FILL on accept with in_sof. That pixel is (0,0); the next pixel is (0,1).
  - FILL→RUN when the pixel at (1, IMG_W-1) is accepted.
  - RUN→IDLE when the pixel at (IMG_H-1, IMG_W-1) is accepted; frame_done=1 on the next cycle.
- Counters:
  - col increments on each accept and wraps from IMG_W-1 to 0.
  - row increments on that wrap; both clear on frame end.
  - Counters always hold the position of the next expected pixel.
- Window generation: when a pixel at (r,c) is accepted with r≥2 and c≥2:
  - on the next edge, win_valid=1, win_row=r-1, win_col=c-1;
  - latency from accept to win_valid is 1 cycle.
- Window hold and release:
  - win_valid stays high, with win_row/win_col stable, until a cycle with win_ready=1; it then clears on that edge unless a new window is set on the same edge.
  - Simultaneous win_ready and accept complete the handoff with no bubble.
- Border: pixels with c<2 or r<2 shift the delay line but produce no window. Windows per frame = (IMG_W-2)*(IMG_H-2).
- Mid-frame SOF: in_sof accepted while busy pulses frame_err for 1 cycle. That pixel restarts the frame as (0,0) in FILL. A pending win_valid is not cancelled; it drains normally.
- A frame_done pulse and a final win_valid may coincide.
- Reset mid-frame: everything returns to its reset value immediately. The delay-line contents are stale and are not cleared by this block; the next SOF refills them.
- in_valid with in_ready=0: nothing changes; upstream must hold its data.

Test Plan (IMG_W=4, IMG_H=3):
- Reset, then 12 pixels with SOF on the first, win_ready=1 → line_ce high for 12 cycles; win_valid exactly 2 cycles, with (row,col)=(1,1) then (1,2); frame_done pulses once, on the cycle after pixel 12; busy returns to 0.
- Non-SOF pixels in IDLE → in_ready=1, line_ce=0, counters stay 0, busy=0.
- Hold win_ready=0 when the first window appears → in_ready=0 and line_ce=0 while stalled; win_row/win_col stay at (1,1); release win_ready → the stream resumes with no pixel lost, and the second window is (1,2).
- SOF reissued at pixel 7 → frame_err pulses 1 cycle, counters restart, and the next frame yields its 2 windows at the correct positions.
- Assert rst=0 during pixel 10 → all outputs go to their reset values asynchronously; a following full frame gives the normal 2 windows.
- Back-to-back frames (SOF on the cycle right after the last pixel) → 4 windows total, 2 frame_done pulses, no frame_err.
